moving_sum_inverse: RTL

- Decoder paired with the RX-side windowed moving-sum/average block.
- Takes the full-width running-sum stream of a 2^WINDOW_SHIFT boxcar and reconstructs the original sample stream exactly.
- Used on the TX/loopback side for self-check of the averaging path, and to regenerate samples from a transported sum-only stream.
- Uses a delay line of previously recovered samples, one sample in and one sample out per strobe.

---
 rtl/moving_sum_inverse.sv | 93 +++++++++
 1 files changed

// File: rtl/moving_sum_inverse.sv
// Purpose : recovers the sample stream x[n] from the running sum of a 2^WINDOW_SHIFT boxcar.
// Latency : 1 cycle from accepted input_strobe to data_out/output_strobe.
// Backpr. : none; one sample per cycle is sustained, and enable low freezes all state.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   enable           block enable; strobes are ignored while low
//   sum_in           signed running sum s[n] (SUM_WIDTH bits)
//   input_strobe     sum_in valid this cycle
//   clear            synchronous restart of warm-up; beats input_strobe
//   data_out         recovered sample x[n] (registered)
//   output_strobe    one-cycle pulse per accepted strobe
//   full             high once N samples have been recovered since reset/clear
module moving_sum_inverse #(
    parameter int DATA_WIDTH   = 32,
    parameter int WINDOW_SHIFT = 4,
    localparam int SUM_WIDTH   = DATA_WIDTH + WINDOW_SHIFT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [SUM_WIDTH-1:0]  sum_in,
    input  logic                  input_strobe,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_strobe,
    output logic                  full
);

    localparam int N = 1 << WINDOW_SHIFT;

    logic [SUM_WIDTH-1:0]    delay_line [N];
    logic [SUM_WIDTH-1:0]    prev_sum;
    logic [WINDOW_SHIFT-1:0] ptr;
    logic [WINDOW_SHIFT-1:0] fill_cnt;

    logic                    accept;
    logic [SUM_WIDTH-1:0]    diff;
    logic [SUM_WIDTH-1:0]    old;
    logic [SUM_WIDTH-1:0]    x;

    assign accept = enable & input_strobe & ~clear;

    // s[n] - s[n-1] = x[n] - x[n-N]; the sample leaving the window is added
    // back once the window has been filled. Everything wraps at SUM_WIDTH,
    // which keeps the result exact even when the running sum overflows.
    assign diff = sum_in - prev_sum;
    // Combinational read happens before the same-edge write at ptr, so the
    // entry seen here is the one written N accepted strobes ago.
    assign old  = delay_line[ptr];
    assign x    = full ? (diff + old) : diff;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out      <= '0;
            output_strobe <= 1'b0;
            full          <= 1'b0;
            ptr           <= '0;
            prev_sum      <= '0;
            fill_cnt      <= '0;
        end else if (clear) begin
            data_out      <= '0;
            output_strobe <= 1'b0;
            full          <= 1'b0;
            ptr           <= '0;
            prev_sum      <= '0;
            fill_cnt      <= '0;
        end else begin
            output_strobe <= accept;
            if (accept) begin
                data_out <= x[DATA_WIDTH-1:0];
                ptr      <= ptr + 1'b1;
                prev_sum <= sum_in;
                if (!full) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    // The N-th accepted strobe sets full alongside its output.
                    if (&fill_cnt) begin
                        full <= 1'b1;
                    end
                end
            end
        end
    end

    // Delay-line contents are never read before being rewritten after a
    // restart (full gates the read), so they carry no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            delay_line[ptr] <= x;
        end
    end

endmodule
